// File: rtl/fifo_stream_reader_if.sv
// Read-port and stream bundle between the dual-clock FIFO, the stream reader and its consumer.
// master = the reader (drives fifo_rd_en and the stream); slave = FIFO plus downstream sink.
interface fifo_stream_reader_if #(
  parameter int DATA_LEN = 16
);
  logic [DATA_LEN-1:0] fifo_data_out;
  logic                fifo_rd_empty;
  logic                fifo_rd_en;
  logic [DATA_LEN-1:0] out_data;
  logic                out_valid;
  logic                out_ready;

  modport master (
    input  fifo_data_out,
    input  fifo_rd_empty,
    input  out_ready,
    output fifo_rd_en,
    output out_data,
    output out_valid
  );

  modport slave (
    output fifo_data_out,
    output fifo_rd_empty,
    output out_ready,
    input  fifo_rd_en,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Turns the FIFO's one-cycle-latency read port into a bubble-free valid/ready stream
// through a 2-entry prefetch buffer, and counts delivered beats.
module fifo_stream_reader #(
  parameter int DATA_LEN = 16,
  parameter int CNT_LEN  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_stream_reader_if.master bus,
  input  logic                 flush,
  output logic [CNT_LEN-1:0]   beat_count,
  output logic                 idle
);

  logic [1:0]          r_cnt;
  logic                r_inflight;
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [DATA_LEN-1:0] r_buf [2];
  logic [CNT_LEN-1:0]  r_beat_count;

  logic                w_pop;
  logic [2:0]          w_occupancy;
  logic                w_issue;

  // Credit counts words already held plus the one returning this cycle, minus the one leaving.
  assign w_pop       = bus.out_valid & bus.out_ready;
  assign w_occupancy = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = ~bus.fifo_rd_empty & ~flush & ~reset & (w_occupancy < 3'd2);

  assign bus.fifo_rd_en = w_issue;
  assign bus.out_valid  = (r_cnt != 2'd0);
  assign bus.out_data   = r_buf[r_rd_ptr];
  assign beat_count     = r_beat_count;
  assign idle           = (r_cnt == 2'd0) & ~r_inflight & bus.fifo_rd_empty;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= 2'd0;
      r_inflight   <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_beat_count <= '0;
    end else begin
      if (w_pop) begin
        r_beat_count <= r_beat_count + CNT_LEN'(1);
      end
      if (flush) begin
        r_cnt      <= 2'd0;
        r_inflight <= 1'b0;
        r_wr_ptr   <= 1'b0;
        r_rd_ptr   <= 1'b0;
      end else begin
        r_cnt      <= w_occupancy[1:0];
        r_inflight <= w_issue;
        if (r_inflight) begin
          r_wr_ptr <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
      end
    end
  end

  // NOTE: buffer storage is not reset; r_cnt and the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_buf[r_wr_ptr] <= bus.fifo_data_out;
    end
  end

  a_cnt_bound : assert property (@(posedge clk) disable iff (reset) r_cnt <= 2'd2);

  a_no_read_when_empty : assert property (@(posedge clk)
    !(bus.fifo_rd_en && bus.fifo_rd_empty));

  a_data_stable : assert property (@(posedge clk) disable iff (reset)
    (bus.out_valid && !bus.out_ready && !flush) |=> $stable(bus.out_data));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomised and directed bench for fifo_stream_reader with an ideal FIFO model and
// an order-preserving scoreboard; a second instance checks beat_count wrap at CNT_LEN=4.
module tb_fifo_stream_reader;

  localparam int DATA_LEN = 16;
  localparam int MEM_SIZE = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        flush;
  logic [31:0] beat_count;
  logic        idle;

  fifo_stream_reader_if #(.DATA_LEN(DATA_LEN)) bus ();

  fifo_stream_reader #(.DATA_LEN(DATA_LEN), .CNT_LEN(32)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.master),
    .flush      (flush),
    .beat_count (beat_count),
    .idle       (idle)
  );

  // Wrap-check instance: endless data source, beat counter only 4 bits wide.
  logic       reset_w;
  logic       flush_w;
  logic [3:0] beat_count_w;
  logic       idle_w;
  logic       wrap_done;

  fifo_stream_reader_if #(.DATA_LEN(DATA_LEN)) bus_w ();
  assign bus_w.fifo_rd_empty = 1'b0;
  assign bus_w.fifo_data_out = 16'h0000;

  fifo_stream_reader #(.DATA_LEN(DATA_LEN), .CNT_LEN(4)) u_dut_w (
    .clk        (clk),
    .reset      (reset_w),
    .bus        (bus_w.master),
    .flush      (flush_w),
    .beat_count (beat_count_w),
    .idle       (idle_w)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Ideal FIFO: words written by the bench, read data appears one cycle after rd_en.
  logic [DATA_LEN-1:0] mem [MEM_SIZE];
  int wr_idx = 0;
  int rd_idx = 0;

  assign bus.fifo_rd_empty = (rd_idx == wr_idx);

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_data_out <= mem[rd_idx];
      rd_idx            <= rd_idx + 1;
    end
  end

  task automatic push(input logic [DATA_LEN-1:0] v);
    if (wr_idx < MEM_SIZE) begin
      mem[wr_idx] = v;
      wr_idx++;
    end
  endtask

  // Reference: words leave in FIFO read order; reset/flush drop every word read but not yet delivered.
  logic [DATA_LEN-1:0] exp_q [$];
  logic [31:0]         exp_beats = 32'd0;
  bit                  mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("beat_count", beat_count, exp_beats);
      if (reset || flush || bus.fifo_rd_empty)
        check("rd_en_gated", {31'd0, bus.fifo_rd_en}, 32'd0);
      if (reset) begin
        exp_q.delete();
        exp_beats = 32'd0;
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) check("unexpected_beat", 32'd0, 32'd1);
          else check("beat_data", {16'd0, bus.out_data}, {16'd0, exp_q.pop_front()});
          exp_beats = exp_beats + 32'd1;
        end
        if (flush) exp_q.delete();
        else if (bus.fifo_rd_en) exp_q.push_back(mem[rd_idx]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (idle) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, {31'd0, ok}, 32'd1);
    check({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int reads;
    reset         = 1'b1;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_idle", {31'd0, idle}, 32'd1);

    // 1: eight preloaded words with ready held high
    tick();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(16'(i + 1));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("t1_rd_en", {31'd0, bus.fifo_rd_en}, {31'd0, (k < 8)});
      check("t1_valid", {31'd0, bus.out_valid}, {31'd0, (k >= 2 && k < 10)});
      tick();
    end
    @(negedge clk);
    check("t1_beats", beat_count, 32'd8);
    check("t1_idle", {31'd0, idle}, 32'd1);

    // 2: backpressure holds exactly two words
    tick();
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(16'h00A0 + 16'(i));
    reads = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.fifo_rd_en) reads++;
      if (k >= 2) begin
        check("t2_valid", {31'd0, bus.out_valid}, 32'd1);
        check("t2_data", {16'd0, bus.out_data}, 32'h00A0);
      end
      tick();
    end
    check("t2_reads", reads, 32'd2);
    check("t2_cnt", {30'd0, u_dut.r_cnt}, 32'd2);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_no_gap", {31'd0, bus.out_valid}, 32'd1);
      tick();
    end
    wait_idle(20, "t2_idle");

    // 3: ready toggling over a 16-word stream
    tick();
    do_reset();
    for (int i = 0; i < 16; i++) push(16'h0010 + 16'(i));
    for (int k = 0; k < 100; k++) begin
      bus.out_ready = (k % 2 == 0);
      @(negedge clk);
      if (idle) break;
      tick();
    end
    check("t3_beats", beat_count, 32'd16);
    check("t3_drained", exp_q.size(), 32'd0);

    // 4: reset the cycle after a read issues, three words left in the FIFO
    tick();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(16'h0040 + 16'(i));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t4_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t4_beats", beat_count, 32'd0);
    wait_idle(20, "t4_idle");
    check("t4_beats_after", beat_count, 32'd3);

    // 5: flush mid-stream after five beats
    tick();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) push(16'h0050 + 16'(i));
    repeat (7) tick();
    flush         = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t5_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t5_beats", beat_count, 32'd5);
    check("t5_resume", {31'd0, bus.fifo_rd_en}, 32'd1);
    wait_idle(30, "t5_idle");
    check("t5_beats_after", beat_count, 32'd10);

    // 7: random pushes, ready, flush and occasional reset
    tick();
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 2) != 0) push(16'($urandom));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 40) == 0);
      reset         = ($urandom_range(0, 300) == 0);
      tick();
    end
    flush         = 1'b0;
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle(3000, "rand_idle");

    for (int i = 0; i < 200 && !wrap_done; i++) @(negedge clk);
    check("wrap_done", {31'd0, wrap_done}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // 6: beat_count wraps modulo 16 on the 4-bit instance
  initial begin
    int pops;
    wrap_done     = 1'b0;
    reset_w       = 1'b1;
    flush_w       = 1'b0;
    bus_w.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_w         = 1'b0;
    bus_w.out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 100 && pops < 17; i++) begin
      @(negedge clk);
      if (bus_w.out_valid) pops++;
    end
    @(posedge clk);
    #1;
    bus_w.out_ready = 1'b0;
    @(negedge clk);
    check("t6_pops", pops, 32'd17);
    check("t6_wrap", {28'd0, beat_count_w}, 32'(17 % 16));
    wrap_done = 1'b1;
  end

endmodule
